axi_burst_pattern_tester: RTL and testbench
===========================================

Name: axi_burst_pattern_tester

Overview:
- AXI4-Lite-controlled traffic generator/checker; successor to axi_master_tester.
- Software programs base address, burst length and seed, then launches an AXI4 INCR write burst of a deterministic pattern, a read burst with on-the-fly compare, or both back-to-back.
- Parametrised data width and maximum burst length; adds mismatch counting and response-error reporting.
- Sits between the host AXI-Lite control bus and a memory-mapped AXI4 slave under test.

Parameters:
ADDR_WIDTH, 32, AXI-Lite address width (only bits [4:2] decoded)
MSTR_ADDR_WIDTH, 32, AXI4 master address width
MSTR_DATA_WIDTH, 32, AXI4 data width (32, 64 or 128)
MSTR_STRB_WIDTH, MSTR_DATA_WIDTH/8, write strobe width
MSTR_ID_WIDTH, 4, AXI ID width; all IDs driven 0
MAX_BURST, 16, maximum beats per burst (power of two, 1..256)

Ports:
i_axi_clk  in  1  clock
i_axi_rst_n  in  1  reset, asynchronous, active-low
i_awvalid/o_awready  in/out  1/1  Lite write address handshake
i_awaddr  in  ADDR_WIDTH  Lite write address
i_wvalid/o_wready  in/out  1/1  Lite write data handshake
i_wdata, i_wstrb  in  32, 4  Lite write data and strobes
o_bvalid/i_bready/o_bresp  out/in/out  1/1/2  Lite write response
i_arvalid/o_arready/i_araddr  in/out/in  1/1/ADDR_WIDTH  Lite read address
o_rvalid/i_rready/o_rresp/o_rdata  out/in/out/out  1/1/2/32  Lite read data
axi_aw{addr,id,len,size,burst,valid}  out  MSTR_ADDR_WIDTH,ID,8,3,2,1  master write address; axi_awready in
axi_w{data,strb,last,valid}  out  DATA,STRB,1,1  master write data; axi_wready in
axi_bresp, axi_bid, axi_bvalid  in  2,ID,1; axi_bready out
axi_ar{addr,id,len,size,burst,valid}  out  as AW; axi_arready in
axi_rdata, axi_rid, axi_rresp, axi_rlast, axi_rvalid  in  DATA,ID,2,1,1; axi_rready out

Behaviour:
Reset: state IDLE. Every valid/ready output is 0; all registers and counters are 0.
Registers (byte offset; other offsets read 0, writes ignored, resp always OKAY):
- 0x00 CTRL (W): bit0 START_WR, bit1 START_RD, bit2 CLR_STATUS. Self-clearing; reads 0.
- 0x04 STATUS (RO): bit0 busy, bit1 done, bit2 mismatch, bit3 resp_err, [31:16] mismatch count (saturates at 0xFFFF).
- 0x08 ADDR: burst base address.
- 0x0C LEN: beats-1 in [7:0]; values above MAX_BURST-1 are stored as MAX_BURST-1.
- 0x10 SEED.
- 0x14 FIRST_BAD (RO): beat index of first mismatch since last clear.
Lite write path:
- o_awready and o_wready assert together for one cycle when i_awvalid, i_wvalid and !o_bvalid.
- Register updates next cycle, honouring i_wstrb bytes.
- o_bvalid rises the cycle after acceptance and holds until i_bready.
Lite read path:
- o_arready = !o_rvalid.
- o_rdata registered; o_rvalid rises next cycle and holds until i_rready.
Pattern: beat i data = SEED + i (32-bit add, mod 2^32), zero-extended to MSTR_DATA_WIDTH.
Master fields: awsize/arsize = log2(MSTR_STRB_WIDTH), burst = 2'b01, len = LEN, wstrb all ones.
FSM IDLE -> W_ADDR -> W_DATA -> W_RESP -> R_ADDR -> R_DATA -> IDLE:
- IDLE: START_WR goes to W_ADDR; START_RD alone goes to R_ADDR. Both set runs the write, then the read. START writes while busy are ignored. Launch clears done.
- W_ADDR: axi_awvalid held until axi_awready.
- W_DATA: axi_wvalid held. Beat counter advances on wready. axi_wlast asserts on beat LEN. Data is stable under stall.
- W_RESP: axi_bready=1. On bvalid, bresp!=0 sets resp_err. Go to R_ADDR if a read is pending, else IDLE with done=1.
- R_ADDR: axi_arvalid held until axi_arready.
- R_DATA: axi_rready=1. Each accepted beat is compared to the pattern. A mismatch increments the count, sets the mismatch bit, and records FIRST_BAD if it was clear. rresp!=0 sets resp_err.
- R_DATA exit on rlast, then done=1. rlast on a beat index != LEN sets mismatch. A beat beyond LEN without rlast also sets mismatch, and the FSM exits at that beat.
CLR_STATUS clears mismatch, resp_err, count, FIRST_BAD and done; it is ignored while busy.
Reset mid-burst: all outputs drop to 0 asynchronously and the FSM returns to IDLE; no partial transaction resumes.
busy = (state != IDLE).

Test Plan:
- ADDR=0x40, LEN=3, SEED=0x100, CTRL=1 -> AW addr 0x40, len 3, size 2, burst 1; W data 0x100..0x103, wlast on 4th beat; STATUS=0x2.
- CTRL=3 with a memory model, random awready/wready/arready stalls 0-5 cycles -> write then read, STATUS=0x2, count 0, data stable under stall.
- Model corrupts read beat 2 -> STATUS mismatch=1, count=1, FIRST_BAD=2; CLR_STATUS -> STATUS=0.
- bresp=2'b10 on write -> resp_err=1, done=1, read still executes when CTRL=3.
- LEN=0xFF with MAX_BURST=16 -> LEN reads 0x0F, awlen=15; early rlast on beat 5 -> mismatch=1.
- Deassert i_axi_rst_n during W_DATA beat 2 -> all valids 0 immediately, busy=0, registers 0; new CTRL=1 runs cleanly.

Source files
------------

// File: rtl/axi_burst_pattern_tester.sv
// AXI4-Lite controlled AXI4 burst generator/checker: writes a seed-based incrementing
// pattern as one INCR burst and reads it back with beat-by-beat comparison.
//
// Handshake rule on every channel: a transfer happens on the rising clock edge where
// valid and ready are both high. A valid, once raised, holds its payload steady until
// that edge.
module axi_burst_pattern_tester #(
    parameter int ADDR_WIDTH      = 32,
    parameter int MSTR_ADDR_WIDTH = 32,
    parameter int MSTR_DATA_WIDTH = 32,
    parameter int MSTR_STRB_WIDTH = MSTR_DATA_WIDTH/8,
    parameter int MSTR_ID_WIDTH   = 4,
    parameter int MAX_BURST       = 16
) (
    input  logic                       i_axi_clk,
    input  logic                       i_axi_rst_n,
    // AXI4-Lite control slave
    input  logic                       i_awvalid,
    output logic                       o_awready,
    input  logic [ADDR_WIDTH-1:0]      i_awaddr,
    input  logic                       i_wvalid,
    output logic                       o_wready,
    input  logic [31:0]                i_wdata,
    input  logic [3:0]                 i_wstrb,
    output logic                       o_bvalid,
    input  logic                       i_bready,
    output logic [1:0]                 o_bresp,
    input  logic                       i_arvalid,
    output logic                       o_arready,
    input  logic [ADDR_WIDTH-1:0]      i_araddr,
    output logic                       o_rvalid,
    input  logic                       i_rready,
    output logic [1:0]                 o_rresp,
    output logic [31:0]                o_rdata,
    // AXI4 master
    output logic [MSTR_ADDR_WIDTH-1:0] axi_awaddr,
    output logic [MSTR_ID_WIDTH-1:0]   axi_awid,
    output logic [7:0]                 axi_awlen,
    output logic [2:0]                 axi_awsize,
    output logic [1:0]                 axi_awburst,
    output logic                       axi_awvalid,
    input  logic                       axi_awready,
    output logic [MSTR_DATA_WIDTH-1:0] axi_wdata,
    output logic [MSTR_STRB_WIDTH-1:0] axi_wstrb,
    output logic                       axi_wlast,
    output logic                       axi_wvalid,
    input  logic                       axi_wready,
    input  logic [1:0]                 axi_bresp,
    input  logic [MSTR_ID_WIDTH-1:0]   axi_bid,
    input  logic                       axi_bvalid,
    output logic                       axi_bready,
    output logic [MSTR_ADDR_WIDTH-1:0] axi_araddr,
    output logic [MSTR_ID_WIDTH-1:0]   axi_arid,
    output logic [7:0]                 axi_arlen,
    output logic [2:0]                 axi_arsize,
    output logic [1:0]                 axi_arburst,
    output logic                       axi_arvalid,
    input  logic                       axi_arready,
    input  logic [MSTR_DATA_WIDTH-1:0] axi_rdata,
    input  logic [MSTR_ID_WIDTH-1:0]   axi_rid,
    input  logic [1:0]                 axi_rresp,
    input  logic                       axi_rlast,
    input  logic                       axi_rvalid,
    output logic                       axi_rready,
    // FSM state for observation
    output logic [2:0]                 dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_W_ADDR = 3'd1,
        S_W_DATA = 3'd2,
        S_W_RESP = 3'd3,
        S_R_ADDR = 3'd4,
        S_R_DATA = 3'd5
    } state_t;

    localparam logic [2:0] BEAT_SIZE = 3'($clog2(MSTR_STRB_WIDTH));
    localparam logic [7:0] LEN_MAX   = 8'(MAX_BURST - 1);

    state_t      state;
    logic [31:0] reg_addr;
    logic [7:0]  reg_len;
    logic [31:0] reg_seed;
    logic [31:0] run_addr;
    logic [7:0]  run_len;
    logic [31:0] run_seed;
    logic        rd_pending;
    logic [8:0]  beat;
    logic        done;
    logic        mismatch;
    logic        resp_err;
    logic [15:0] mis_count;
    logic [8:0]  first_bad;
    logic        rd_ready_en;

    // ------------------------------------------------------------------
    // Lite write path
    // ------------------------------------------------------------------
    logic       wr_hs;
    logic [2:0] wr_sel;
    logic       ctrl_wr;
    logic       cmd_wr;
    logic       cmd_rd;
    logic       cmd_clr;

    assign wr_hs   = o_awready && i_awvalid && i_wvalid;
    assign wr_sel  = i_awaddr[4:2];
    assign ctrl_wr = wr_hs && (wr_sel == 3'd0) && i_wstrb[0];
    assign cmd_wr  = ctrl_wr && i_wdata[0];
    assign cmd_rd  = ctrl_wr && i_wdata[1];
    assign cmd_clr = ctrl_wr && i_wdata[2];
    assign o_bresp = 2'b00;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    always_ff @(posedge i_axi_clk or negedge i_axi_rst_n) begin
        if (!i_axi_rst_n) begin
            o_awready <= 1'b0;
            o_wready  <= 1'b0;
            o_bvalid  <= 1'b0;
            reg_addr  <= '0;
            reg_len   <= '0;
            reg_seed  <= '0;
        end else begin
            // One-cycle accept pulse; the !o_awready term stops a second accept
            // of the same request on the cycle the handshake completes.
            o_awready <= i_awvalid && i_wvalid && !o_bvalid && !o_awready;
            o_wready  <= i_awvalid && i_wvalid && !o_bvalid && !o_awready;
            if (wr_hs) begin
                o_bvalid <= 1'b1;
                case (wr_sel)
                    3'd2: reg_addr <= merge_bytes(reg_addr, i_wdata, i_wstrb);
                    3'd3: begin
                        if (i_wstrb[0])
                            reg_len <= (i_wdata[7:0] > LEN_MAX) ? LEN_MAX : i_wdata[7:0];
                    end
                    3'd4: reg_seed <= merge_bytes(reg_seed, i_wdata, i_wstrb);
                    default: ;
                endcase
            end else if (o_bvalid && i_bready) begin
                o_bvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Lite read path
    // ------------------------------------------------------------------
    logic        rd_hs;
    logic [31:0] rd_mux;
    logic        busy;

    assign busy      = (state != S_IDLE);
    assign o_arready = rd_ready_en && !o_rvalid;
    assign rd_hs     = o_arready && i_arvalid;
    assign o_rresp   = 2'b00;

    always_comb begin
        rd_mux = 32'h0;
        case (i_araddr[4:2])
            3'd1: rd_mux = {mis_count, 12'h000, resp_err, mismatch, done, busy};
            3'd2: rd_mux = reg_addr;
            3'd3: rd_mux = {24'h0, reg_len};
            3'd4: rd_mux = reg_seed;
            3'd5: rd_mux = {23'h0, first_bad};
            default: rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge i_axi_clk or negedge i_axi_rst_n) begin
        if (!i_axi_rst_n) begin
            rd_ready_en <= 1'b0;
            o_rvalid    <= 1'b0;
            o_rdata     <= '0;
        end else begin
            rd_ready_en <= 1'b1;
            if (rd_hs) begin
                o_rvalid <= 1'b1;
                o_rdata  <= rd_mux;
            end else if (o_rvalid && i_rready) begin
                o_rvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pattern and master address fields
    // ------------------------------------------------------------------
    logic [31:0]                exp_word;
    logic [MSTR_DATA_WIDTH-1:0] pattern_wide;
    logic [63:0]                addr_ext;

    assign exp_word = run_seed + {23'h0, beat};
    assign addr_ext = {32'h0, run_addr};

    always_comb begin
        pattern_wide       = '0;
        pattern_wide[31:0] = exp_word;
    end

    assign axi_awaddr  = addr_ext[MSTR_ADDR_WIDTH-1:0];
    assign axi_araddr  = addr_ext[MSTR_ADDR_WIDTH-1:0];
    assign axi_awlen   = run_len;
    assign axi_arlen   = run_len;
    assign axi_awsize  = BEAT_SIZE;
    assign axi_arsize  = BEAT_SIZE;
    assign axi_awburst = 2'b01;
    assign axi_arburst = 2'b01;
    assign axi_awid    = '0;
    assign axi_arid    = '0;
    assign axi_wstrb   = '1;
    assign axi_wdata   = pattern_wide;
    assign dbg_state   = state;

    // Read beat classification: bad data, rlast on the wrong beat, or a beat past LEN.
    logic beat_over;
    logic last_bad;
    logic beat_bad;

    assign beat_over = beat > {1'b0, run_len};
    assign last_bad  = axi_rlast ? (beat != {1'b0, run_len}) : beat_over;
    assign beat_bad  = (axi_rdata != pattern_wide) || last_bad;

    // ------------------------------------------------------------------
    // Burst sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge i_axi_clk or negedge i_axi_rst_n) begin
        if (!i_axi_rst_n) begin
            state       <= S_IDLE;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_wlast   <= 1'b0;
            axi_bready  <= 1'b0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
            beat        <= '0;
            run_addr    <= '0;
            run_len     <= '0;
            run_seed    <= '0;
            rd_pending  <= 1'b0;
            done        <= 1'b0;
            mismatch    <= 1'b0;
            resp_err    <= 1'b0;
            mis_count   <= '0;
            first_bad   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_clr) begin
                        done      <= 1'b0;
                        mismatch  <= 1'b0;
                        resp_err  <= 1'b0;
                        mis_count <= '0;
                        first_bad <= '0;
                    end
                    if (cmd_wr || cmd_rd) begin
                        run_addr   <= reg_addr;
                        run_len    <= reg_len;
                        run_seed   <= reg_seed;
                        beat       <= '0;
                        done       <= 1'b0;
                        rd_pending <= cmd_wr && cmd_rd;
                        if (cmd_wr) begin
                            state       <= S_W_ADDR;
                            axi_awvalid <= 1'b1;
                        end else begin
                            state       <= S_R_ADDR;
                            axi_arvalid <= 1'b1;
                        end
                    end
                end
                S_W_ADDR: begin
                    if (axi_awready) begin
                        axi_awvalid <= 1'b0;
                        axi_wvalid  <= 1'b1;
                        axi_wlast   <= (run_len == 8'd0);
                        beat        <= '0;
                        state       <= S_W_DATA;
                    end
                end
                S_W_DATA: begin
                    if (axi_wready) begin
                        if (axi_wlast) begin
                            axi_wvalid <= 1'b0;
                            axi_wlast  <= 1'b0;
                            axi_bready <= 1'b1;
                            state      <= S_W_RESP;
                        end else begin
                            beat      <= beat + 9'd1;
                            axi_wlast <= ((beat + 9'd1) == {1'b0, run_len});
                        end
                    end
                end
                S_W_RESP: begin
                    if (axi_bvalid) begin
                        axi_bready <= 1'b0;
                        if (axi_bresp != 2'b00) resp_err <= 1'b1;
                        if (rd_pending) begin
                            rd_pending  <= 1'b0;
                            axi_arvalid <= 1'b1;
                            state       <= S_R_ADDR;
                        end else begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end
                end
                S_R_ADDR: begin
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        axi_rready  <= 1'b1;
                        beat        <= '0;
                        state       <= S_R_DATA;
                    end
                end
                S_R_DATA: begin
                    if (axi_rvalid) begin
                        if (axi_rresp != 2'b00) resp_err <= 1'b1;
                        if (beat_bad) begin
                            mismatch <= 1'b1;
                            if (!mismatch) first_bad <= beat;
                            if (mis_count != 16'hFFFF) mis_count <= mis_count + 16'd1;
                        end
                        if (axi_rlast || beat_over) begin
                            axi_rready <= 1'b0;
                            done       <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            beat <= beat + 9'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Address bits above [4:2] and response IDs carry no information here.
    logic unused_bits;
    assign unused_bits = ^{i_awaddr, i_araddr, axi_bid, axi_rid, addr_ext};

endmodule

// File: tb/tb_axi_burst_pattern_tester.sv
// Bench for axi_burst_pattern_tester: register vector table, then burst scenarios
// against a stalling AXI4 memory model with a write-data scoreboard.
module tb_axi_burst_pattern_tester;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_awvalid, o_awready, i_wvalid, o_wready, o_bvalid, i_bready;
    logic [31:0] i_awaddr, i_wdata, i_araddr, o_rdata;
    logic [3:0]  i_wstrb;
    logic [1:0]  o_bresp, o_rresp;
    logic        i_arvalid, o_arready, o_rvalid, i_rready;
    logic [31:0] axi_awaddr, axi_araddr, axi_wdata, axi_rdata;
    logic [3:0]  axi_awid, axi_arid, axi_bid, axi_rid, axi_wstrb;
    logic [7:0]  axi_awlen, axi_arlen;
    logic [2:0]  axi_awsize, axi_arsize, dbg_state;
    logic [1:0]  axi_awburst, axi_arburst, axi_bresp, axi_rresp;
    logic        axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
    logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready;
    logic        axi_rlast, axi_rvalid, axi_rready;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem[256];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } reg_vec_t;
    reg_vec_t vecs[9];

    axi_burst_pattern_tester dut (
        .i_axi_clk(clk), .i_axi_rst_n(rst_n),
        .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awaddr(i_awaddr),
        .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
        .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bresp(o_bresp),
        .i_arvalid(i_arvalid), .o_arready(o_arready), .i_araddr(i_araddr),
        .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rresp(o_rresp), .o_rdata(o_rdata),
        .axi_awaddr(axi_awaddr), .axi_awid(axi_awid), .axi_awlen(axi_awlen),
        .axi_awsize(axi_awsize), .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bid(axi_bid), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready), .axi_araddr(axi_araddr), .axi_arid(axi_arid),
        .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_rdata(axi_rdata),
        .axi_rid(axi_rid), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at 1ms, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no handshake, required one within budget", name);
    endtask

    // ---------------- Lite driver tasks ----------------
    task automatic lite_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        i_awaddr = a; i_wdata = d; i_wstrb = s;
        i_awvalid = 1'b1; i_wvalid = 1'b1;
        while (!o_awready && n < 50) begin @(posedge clk); #1; n++; end
        if (!o_awready) begin
            timeout("lite_aw");
            i_awvalid = 1'b0; i_wvalid = 1'b0;
            return;
        end
        check("lite_wready", o_wready, 1);
        @(posedge clk); #1;
        i_awvalid = 1'b0; i_wvalid = 1'b0;
        check("lite_bvalid", o_bvalid, 1);
        check("lite_bresp", o_bresp, 0);
        i_bready = 1'b1;
        @(posedge clk); #1;
        i_bready = 1'b0;
    endtask

    task automatic lite_read(input logic [31:0] a, output logic [31:0] d);
        int n = 0;
        d = 32'hxxxx_xxxx;
        i_araddr = a; i_arvalid = 1'b1;
        while (!o_arready && n < 50) begin @(posedge clk); #1; n++; end
        if (!o_arready) begin timeout("lite_ar"); i_arvalid = 1'b0; return; end
        @(posedge clk); #1;
        i_arvalid = 1'b0;
        n = 0;
        while (!o_rvalid && n < 50) begin @(posedge clk); #1; n++; end
        if (!o_rvalid) begin timeout("lite_r"); return; end
        d = o_rdata;
        check("lite_rresp", o_rresp, 0);
        i_rready = 1'b1;
        @(posedge clk); #1;
        i_rready = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        lite_read(a, v);
        check(name, v, exp);
    endtask

    task automatic push_pattern(input logic [31:0] seed, input int len);
        for (int i = 0; i <= len; i++) exp_q.push_back(seed + 32'(i));
    endtask

    // ---------------- AXI4 slave model ----------------
    task automatic slave_write(input int stall_max, input logic [1:0] bresp_v,
                               input logic [31:0] exp_addr, input int exp_len);
        int n = 0;
        int k;
        int base = int'(exp_addr >> 2);
        logic [31:0] d;
        while (!axi_awvalid && n < 200) begin @(posedge clk); #1; n++; end
        if (!axi_awvalid) begin timeout("aw_wait"); return; end
        k = $urandom_range(stall_max, 0);
        repeat (k) begin @(posedge clk); #1; end
        check("awvalid_held", axi_awvalid, 1);
        check("awaddr", axi_awaddr, exp_addr);
        check("awlen", axi_awlen, exp_len);
        check("awsize", axi_awsize, 2);
        check("awburst", axi_awburst, 1);
        check("awid", axi_awid, 0);
        axi_awready = 1'b1;
        @(posedge clk); #1;
        axi_awready = 1'b0;
        for (int i = 0; i <= exp_len; i++) begin
            n = 0;
            while (!axi_wvalid && n < 200) begin @(posedge clk); #1; n++; end
            if (!axi_wvalid) begin timeout("w_wait"); return; end
            k = $urandom_range(stall_max, 0);
            repeat (k) begin
                if (exp_q.size() > 0) check("wdata_stall", axi_wdata, exp_q[0]);
                @(posedge clk); #1;
            end
            check("wlast", axi_wlast, (i == exp_len));
            check("wstrb", axi_wstrb, 4'hF);
            d = axi_wdata;
            if (exp_q.size() == 0) timeout("exp_q_empty");
            else check("wdata", d, exp_q.pop_front());
            mem[(base + i) & 255] = d;
            axi_wready = 1'b1;
            @(posedge clk); #1;
            axi_wready = 1'b0;
        end
        axi_bresp = bresp_v;
        axi_bvalid = 1'b1;
        n = 0;
        while (!axi_bready && n < 200) begin @(posedge clk); #1; n++; end
        if (!axi_bready) begin timeout("b_wait"); axi_bvalid = 1'b0; return; end
        @(posedge clk); #1;
        axi_bvalid = 1'b0;
        axi_bresp = 2'b00;
    endtask

    task automatic slave_read(input int stall_max, input int corrupt_beat, input int end_beat,
                              input logic [31:0] exp_addr, input int exp_len);
        int n = 0;
        int k;
        int base = int'(exp_addr >> 2);
        while (!axi_arvalid && n < 200) begin @(posedge clk); #1; n++; end
        if (!axi_arvalid) begin timeout("ar_wait"); return; end
        k = $urandom_range(stall_max, 0);
        repeat (k) begin @(posedge clk); #1; end
        check("araddr", axi_araddr, exp_addr);
        check("arlen", axi_arlen, exp_len);
        check("arsize", axi_arsize, 2);
        check("arburst", axi_arburst, 1);
        axi_arready = 1'b1;
        @(posedge clk); #1;
        axi_arready = 1'b0;
        for (int i = 0; i <= end_beat; i++) begin
            k = $urandom_range(stall_max, 0);
            repeat (k) begin @(posedge clk); #1; end
            axi_rdata  = mem[(base + i) & 255] ^ ((i == corrupt_beat) ? 32'h1 : 32'h0);
            axi_rlast  = (i == end_beat);
            axi_rresp  = 2'b00;
            axi_rvalid = 1'b1;
            n = 0;
            while (!axi_rready && n < 200) begin @(posedge clk); #1; n++; end
            if (!axi_rready) begin timeout("r_wait"); axi_rvalid = 1'b0; return; end
            @(posedge clk); #1;
            axi_rvalid = 1'b0;
            axi_rlast  = 1'b0;
        end
        check("rready_drop", axi_rready, 0);
    endtask

    task automatic program_regs(input logic [31:0] a, input logic [31:0] len, input logic [31:0] seed);
        lite_write(32'h08, a, 4'hF);
        lite_write(32'h0C, len, 4'hF);
        lite_write(32'h10, seed, 4'hF);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] seed;
        int n;
        rst_n = 1'b0;
        i_awvalid = 0; i_awaddr = 0; i_wvalid = 0; i_wdata = 0; i_wstrb = 0; i_bready = 0;
        i_arvalid = 0; i_araddr = 0; i_rready = 0;
        axi_awready = 0; axi_wready = 0; axi_bresp = 0; axi_bid = 0; axi_bvalid = 0;
        axi_arready = 0; axi_rdata = 0; axi_rid = 0; axi_rresp = 0; axi_rlast = 0; axi_rvalid = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        vecs[0] = '{32'h08, 32'h1234_5678, 4'hF,    32'h1234_5678};
        vecs[1] = '{32'h08, 32'hAABB_CCDD, 4'b0011, 32'h1234_CCDD};
        vecs[2] = '{32'h0C, 32'h0000_00FF, 4'hF,    32'h0000_000F};
        vecs[3] = '{32'h0C, 32'h0000_0005, 4'hF,    32'h0000_0005};
        vecs[4] = '{32'h0C, 32'h0000_0009, 4'b1110, 32'h0000_0005};
        vecs[5] = '{32'h10, 32'hDEAD_BEEF, 4'hF,    32'hDEAD_BEEF};
        vecs[6] = '{32'h10, 32'h0000_0011, 4'b1000, 32'h00AD_BEEF};
        vecs[7] = '{32'h18, 32'hFFFF_FFFF, 4'hF,    32'h0000_0000};
        vecs[8] = '{32'h00, 32'h0000_0000, 4'hF,    32'h0000_0000};

        repeat (3) @(posedge clk);
        #1;
        check("reset_master_valids",
              {axi_awvalid, axi_wvalid, axi_wlast, axi_bready, axi_arvalid, axi_rready}, 0);
        check("reset_lite_handshakes", {o_awready, o_wready, o_bvalid, o_rvalid}, 0);
        check("reset_state", dbg_state, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reg("reset_status", 32'h04, 32'h0);
        check_reg("reset_addr", 32'h08, 32'h0);
        check_reg("reset_first_bad", 32'h14, 32'h0);

        // Register access table
        for (int i = 0; i < 9; i++) begin
            lite_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            check_reg($sformatf("regvec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // Single write burst, no stalls
        program_regs(32'h40, 32'd3, 32'h100);
        push_pattern(32'h100, 3);
        lite_write(32'h00, 32'h1, 4'hF);
        slave_write(0, 2'b00, 32'h40, 3);
        check_reg("t1_status", 32'h04, 32'h2);
        check("t1_exp_q_drained", exp_q.size(), 0);

        // Write then read with random stalls, then read-only re-run
        seed = $urandom;
        program_regs(32'h100, 32'd7, seed);
        push_pattern(seed, 7);
        lite_write(32'h00, 32'h3, 4'hF);
        slave_write(5, 2'b00, 32'h100, 7);
        slave_read(5, -1, 7, 32'h100, 7);
        check_reg("t2_status", 32'h04, 32'h2);
        lite_write(32'h00, 32'h2, 4'hF);
        slave_read(3, -1, 7, 32'h100, 7);
        check_reg("t2_rd_only_status", 32'h04, 32'h2);

        // Corrupted read beat, then clear
        program_regs(32'h200, 32'd3, 32'hCAFE_0000);
        push_pattern(32'hCAFE_0000, 3);
        lite_write(32'h00, 32'h3, 4'hF);
        slave_write(2, 2'b00, 32'h200, 3);
        slave_read(2, 2, 3, 32'h200, 3);
        check_reg("t3_status", 32'h04, 32'h0001_0006);
        check_reg("t3_first_bad", 32'h14, 32'h2);
        lite_write(32'h00, 32'h4, 4'hF);
        check_reg("t3_status_clr", 32'h04, 32'h0);
        check_reg("t3_first_bad_clr", 32'h14, 32'h0);

        // Write response error; the read still runs
        program_regs(32'h300, 32'd2, 32'h55);
        push_pattern(32'h55, 2);
        lite_write(32'h00, 32'h3, 4'hF);
        slave_write(1, 2'b10, 32'h300, 2);
        slave_read(1, -1, 2, 32'h300, 2);
        check_reg("t4_status", 32'h04, 32'hA);
        lite_write(32'h00, 32'h4, 4'hF);

        // LEN clamp and early rlast; the seed wraps past 2^32
        program_regs(32'h0, 32'hFF, 32'hFFFF_FFF8);
        check_reg("t5_len_clamp", 32'h0C, 32'h0F);
        push_pattern(32'hFFFF_FFF8, 15);
        lite_write(32'h00, 32'h3, 4'hF);
        slave_write(0, 2'b00, 32'h0, 15);
        slave_read(0, -1, 5, 32'h0, 15);
        check_reg("t5_status", 32'h04, 32'h0001_0006);
        check_reg("t5_first_bad", 32'h14, 32'h5);
        lite_write(32'h00, 32'h4, 4'hF);

        // Reset in the middle of the write data phase
        program_regs(32'h80, 32'd3, 32'h1000);
        lite_write(32'h00, 32'h1, 4'hF);
        n = 0;
        while (!axi_awvalid && n < 200) begin @(posedge clk); #1; n++; end
        if (!axi_awvalid) timeout("t6_aw");
        axi_awready = 1'b1;
        @(posedge clk); #1;
        axi_awready = 1'b0;
        axi_wready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        axi_wready = 1'b0;
        check("t6_beat2_data", axi_wdata, 32'h1002);
        check("t6_state_wdata", dbg_state, 2);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_valids",
              {axi_awvalid, axi_wvalid, axi_wlast, axi_bready, axi_arvalid, axi_rready}, 0);
        check("t6_async_state", dbg_state, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reg("t6_status", 32'h04, 32'h0);
        check_reg("t6_addr", 32'h08, 32'h0);
        check_reg("t6_seed", 32'h10, 32'h0);
        program_regs(32'h80, 32'd1, 32'h2000);
        push_pattern(32'h2000, 1);
        lite_write(32'h00, 32'h1, 4'hF);
        slave_write(1, 2'b00, 32'h80, 1);
        check_reg("t6_rerun_status", 32'h04, 32'h2);
        check("t6_exp_q_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
